multdiv_ctrl: RTL and testbench

- Sequencing controller for signed 32-bit multiply and divide.
- Iterates over one shared 32-bit add/subtract datapath, one step per clock, and sits beside the bitwise/add ALU in the execute stage.
- The pipeline stalls on busy and takes the result on the single-cycle result_ready pulse.

---
 rtl/multdiv_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_ctrl
// Description : Sequencing controller for signed 32-bit multiply (radix-2
//               Booth) and divide (restoring, on magnitudes, truncating
//               toward zero). One step per clock runs on a single shared
//               add/subtract datapath. Each operation takes 33 cycles from
//               the accepting edge to the result_ready pulse.
// Ports       :
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start_mult   in   multiply request (wins if start_div is also high)
//   start_div    in   divide request
//   operand_a    in   multiplicand / dividend, captured at the accepting edge
//   operand_b    in   multiplier / divisor, captured at the accepting edge
//   result       out  low half of the product, or the quotient
//   exception    out  product overflow, divide-by-zero or MIN/-1 overflow
//   result_ready out  one-cycle pulse, result and exception valid
//   busy         out  operation in progress, starts are ignored
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_is_div;
    logic             r_neg;       // divide: quotient must be negated
    logic             r_div_zero;  // divide: divisor was zero
    // Multiply: r_hi = accumulator, r_lo = multiplier shifting right,
    //           r_lo_m1 = Booth's extra bit below r_lo[0].
    // Divide:   r_hi = partial remainder, r_lo = dividend shifting out
    //           at the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_lo_m1;
    logic [WIDTH-1:0] r_opb;       // multiplicand, or divisor magnitude

    // ------------------------------------------------------------------
    // Operand magnitudes for divide (0x80000000 maps to itself, which is
    // the correct unsigned magnitude).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    assign w_a_mag = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    assign w_b_mag = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;

    // ------------------------------------------------------------------
    // Shared adder
    // ------------------------------------------------------------------
    logic             w_booth_en;
    logic             w_booth_sub;
    logic [WIDTH:0]   w_part;      // shifted partial remainder, 33 bits
    logic [WIDTH-1:0] w_add_x;
    logic [WIDTH-1:0] w_add_y;
    logic             w_sub;
    logic [WIDTH:0]   w_sum_full;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    assign w_booth_en  = r_lo[0] ^ r_lo_m1;
    assign w_booth_sub = r_lo[0] & ~r_lo_m1;
    assign w_part      = {r_hi, r_lo[WIDTH-1]};

    assign w_add_x    = r_is_div ? w_part[WIDTH-1:0] : r_hi;
    assign w_sub      = r_is_div ? 1'b1 : w_booth_sub;
    assign w_add_y    = r_opb ^ {WIDTH{w_sub}};
    assign w_sum_full = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_sub};
    assign w_sum      = w_sum_full[WIDTH-1:0];
    assign w_cout     = w_sum_full[WIDTH];

    // Multiply step: the accumulator can overflow when the multiplicand is
    // the most negative value, so the bit shifted into the top is the true
    // sign of the sum rather than its raw MSB.
    logic             w_add_ovf;
    logic             w_true_sign;
    logic [WIDTH-1:0] w_mul_hi;
    logic             w_mul_sign;
    assign w_add_ovf   = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);
    assign w_true_sign = w_sum[WIDTH-1] ^ w_add_ovf;
    assign w_mul_hi    = w_booth_en ? w_sum : r_hi;
    assign w_mul_sign  = w_booth_en ? w_true_sign : r_hi[WIDTH-1];

    // Divide step: carry-out means no borrow. A set bit shifted out of the
    // remainder already guarantees the shifted value exceeds the divisor.
    logic             w_ge;
    logic [WIDTH-1:0] w_rem;
    assign w_ge  = w_part[WIDTH] | w_cout;
    assign w_rem = w_ge ? w_sum : w_part[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Final result formation
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_prod_top;  // product[63:31]
    logic             w_mul_exc;
    logic [WIDTH-1:0] w_q_neg;
    assign w_prod_top = {r_hi, r_lo[WIDTH-1]};
    assign w_mul_exc  = !((&w_prod_top) || (~|w_prod_top));
    assign w_q_neg    = ~r_lo + 1'b1;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_is_div     <= 1'b0;
            r_neg        <= 1'b0;
            r_div_zero   <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_lo_m1      <= 1'b0;
            r_opb        <= '0;
            result       <= '0;
            exception    <= 1'b0;
            result_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    result_ready <= 1'b0;
                    if (start_mult || start_div) begin
                        r_count <= '0;
                        r_hi    <= '0;
                        r_lo_m1 <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                        if (start_mult) begin
                            r_is_div   <= 1'b0;
                            r_lo       <= operand_b;
                            r_opb      <= operand_a;
                            r_neg      <= 1'b0;
                            r_div_zero <= 1'b0;
                        end else begin
                            r_is_div   <= 1'b1;
                            r_lo       <= w_a_mag;
                            r_opb      <= w_b_mag;
                            r_neg      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                            r_div_zero <= (operand_b == '0);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= {r_lo[WIDTH-2:0], w_ge};
                    end else begin
                        r_hi    <= {w_mul_sign, w_mul_hi[WIDTH-1:1]};
                        r_lo    <= {w_mul_hi[0], r_lo[WIDTH-1:1]};
                        r_lo_m1 <= r_lo[0];
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == C_LAST_STEP) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (!r_is_div) begin
                        result    <= r_lo;
                        exception <= w_mul_exc;
                    end else if (r_div_zero) begin
                        result    <= '0;
                        exception <= 1'b1;
                    end else if (r_neg) begin
                        result    <= w_q_neg;
                        exception <= 1'b0;
                    end else begin
                        // A positive quotient with the top bit set can only
                        // come from MIN / -1.
                        result    <= r_lo;
                        exception <= r_lo[WIDTH-1];
                    end
                    result_ready <= 1'b1;
                    busy         <= 1'b0;
                    r_state      <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_ctrl
// Description : Scoreboard bench for multdiv_ctrl. The driver pushes the
//               hand-computed expected result for each accepted operation;
//               a monitor pops and compares on every result_ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] result;
    logic        exception;
    logic        result_ready;
    logic        busy;

    multdiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .result       (result),
        .exception    (exception),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          t;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every result_ready pulse against the scoreboard.
    logic prev_ready = 1'b0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (result_ready) begin
                check("ready_one_cycle", 64'(prev_ready), 64'(0));
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", 64'(result), 64'(e.r));
                    check("exception", 64'(exception), 64'(e.e));
                    check("latency", 64'(cyc - e.t), 64'(33));
                    check("busy_low_at_ready", 64'(busy), 64'(0));
                end
            end
            prev_ready = result_ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    // Called at a negedge; returns 1 ns after the accepting edge.
    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic push,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        start_mult = m;
        start_div  = d;
        operand_a  = a;
        operand_b  = b;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = 32'hDEADBEEF;
        operand_b  = 32'h12345678;
        check("busy_after_accept", 64'(busy), 64'(1));
        if (push) begin
            e.r = er;
            e.e = ee;
            e.t = cyc;
            sb_q.push_back(e);
        end
    endtask

    // Waits (bounded) until result_ready is seen at a negedge.
    task automatic wait_ready();
        int  n   = 0;
        bit  bad = 1'b0;
        forever begin
            @(negedge clock);
            if (result_ready) break;
            if (!busy) bad = 1'b1;
            n++;
            if (n > 40) begin
                check("ready_timeout", 64'(1), 64'(0));
                break;
            end
        end
        check("busy_during_op", 64'(bad), 64'(0));
    endtask

    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ee);
        @(negedge clock);
        issue(m, d, a, b, 1'b1, er, ee);
        wait_ready();
    endtask

    initial begin
        #1;
        check("reset_result", 64'(result), 64'(0));
        check("reset_exception", 64'(exception), 64'(0));
        check("reset_ready", 64'(result_ready), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Multiply
        run_op(1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op(1, 0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);

        // Divide
        run_op(0, 1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0);
        run_op(0, 1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
        run_op(0, 1, 32'd5,        32'd0,        32'h00000000, 1'b1);
        run_op(0, 1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);

        // start_div pulsed mid-multiply is ignored
        @(negedge clock);
        issue(1, 0, 32'd1000, 32'hFFFFFC18, 1'b1, 32'hFFF0BDC0, 1'b0);
        repeat (10) @(negedge clock);
        start_div = 1'b1;
        operand_a = 32'd50;
        operand_b = 32'd5;
        @(negedge clock);
        start_div = 1'b0;
        wait_ready();

        // Both starts together: multiply wins (divide would give 1)
        run_op(1, 1, 32'd12, 32'd11, 32'd132, 1'b0);

        // Back-to-back: issued in the DONE cycle right after the pulse
        issue(0, 1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 1'b0);
        wait_ready();

        // Leaves result/exception non-zero before the reset test
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);

        // Reset 15 cycles into a divide, checked between clock edges
        @(negedge clock);
        issue(0, 1, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0);
        repeat (15) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_result", 64'(result), 64'(0));
        check("async_rst_exception", 64'(exception), 64'(0));
        check("async_rst_ready", 64'(result_ready), 64'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_busy", 64'(busy), 64'(0));

        run_op(1, 0, 32'd6, 32'd6, 32'd36, 1'b0);

        // Nothing should remain outstanding or appear late
        repeat (40) @(negedge clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
